// File: rtl/bcd_display_pkg.sv
// Shared definitions for the BCD display path: digit count, digit index type
// and the active-low 7-segment codes, bit order {g,f,e,d,c,b,a}.
package bcd_display_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;

    // Active-low segment patterns, ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder. Non-BCD codes (10..15)
// render as a dash so corrupted digits are visible rather than silently wrong.
module bcd_to_seg
    import bcd_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Table lookup of the segment pattern for one digit
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 4-digit common-anode display driver. Snapshots BCD digits
// on i_load and scans them one digit per REFRESH_DIV cycles.
// Optional feature: define BCD_SCAN_BLANK_EN for leading-zero blanking.
module bcd_display_scanner
    import bcd_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DP_POS      = 3
) (
    input  logic       i_clock,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic [3:0] i_bcd3,
    input  logic [3:0] i_bcd2,
    input  logic [3:0] i_bcd1,
    input  logic [3:0] i_bcd0,
    output logic [6:0] o_seg,
    output logic       o_dp,
    output logic [3:0] o_an
);

    localparam int unsigned PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);
    // DP_POS beyond the last digit disables the decimal point entirely
    localparam bit         DP_EN  = (DP_POS < NUM_DIGITS);
    localparam digit_idx_t DP_IDX = digit_idx_t'(DP_POS);

    logic [PRESC_W-1:0] r_presc;
    digit_idx_t         r_idx;
    logic [3:0]         r_snap [NUM_DIGITS];
    logic [6:0]         r_seg;
    logic               r_dp;
    logic [3:0]         r_an;

    logic               w_tick;
    logic [3:0]         w_digit;
    logic [6:0]         w_dec;
    logic [6:0]         w_seg_next;
    logic [3:0]         w_an_next;
    logic               w_dp_next;

    assign w_tick = (r_presc == PRESC_MAX);

    // Snapshot register: clear wins over load, otherwise hold
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                r_snap[k] <= 4'd0;
            end
        end else if (i_load) begin
            r_snap[3] <= i_bcd3;
            r_snap[2] <= i_bcd2;
            r_snap[1] <= i_bcd1;
            r_snap[0] <= i_bcd0;
        end
    end

    // Prescaler: counts 0..REFRESH_DIV-1 then wraps
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Digit index: advances once per dwell, wrapping 3 -> 0 naturally
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_idx <= '0;
        end else if (w_tick) begin
            r_idx <= r_idx + digit_idx_t'(1);
        end
    end

    assign w_digit = r_snap[r_idx];

    bcd_to_seg u_bcd_to_seg (
        .i_bcd (w_digit),
        .o_seg (w_dec)
    );

`ifdef BCD_SCAN_BLANK_EN
    logic [NUM_DIGITS-1:0] w_blank;
    logic                  w_above;

    // Leading-zero mask: walk down from the top digit; the run of blanks stops
    // at the first nonzero digit, at the DP digit, or at digit 0.
    always_comb begin
        w_blank = '0;
        w_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_above = w_above && (r_snap[k] == 4'd0)
                      && (!DP_EN || (k > int'(DP_POS)));
            w_blank[k] = w_above;
        end
    end

    assign w_seg_next = w_blank[r_idx] ? SEG_BLANK : w_dec;
`else
    assign w_seg_next = w_dec;
`endif

    assign w_an_next = ~(4'b0001 << r_idx);
    assign w_dp_next = ~(DP_EN && (r_idx == DP_IDX));

    // Output register: one edge behind the index/snapshot state
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
            r_dp  <= w_dp_next;
        end
    end

    assign o_an  = r_an;
    assign o_seg = r_seg;
    assign o_dp  = r_dp;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner. Two instances share the inputs:
// DUT A (DP_POS=3) and DUT B (DP_POS=1) for the leading-zero blanking case.
module tb_bcd_display_scanner;

    logic       clk = 1'b0;
    logic       clear;
    logic       load;
    logic [3:0] bcd3, bcd2, bcd1, bcd0;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [3:0] an_a, an_b;

    always #5 clk = ~clk;

    bcd_display_scanner #(.REFRESH_DIV(4), .DP_POS(3)) u_dut_a (
        .i_clock (clk),
        .i_clear (clear),
        .i_load  (load),
        .i_bcd3  (bcd3),
        .i_bcd2  (bcd2),
        .i_bcd1  (bcd1),
        .i_bcd0  (bcd0),
        .o_seg   (seg_a),
        .o_dp    (dp_a),
        .o_an    (an_a)
    );

    bcd_display_scanner #(.REFRESH_DIV(4), .DP_POS(1)) u_dut_b (
        .i_clock (clk),
        .i_clear (clear),
        .i_load  (load),
        .i_bcd3  (bcd3),
        .i_bcd2  (bcd2),
        .i_bcd1  (bcd1),
        .i_bcd0  (bcd0),
        .o_seg   (seg_b),
        .o_dp    (dp_b),
        .o_an    (an_b)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [6:0] seg_b;
        logic       dp_b;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;

    // Reference state
    logic [3:0] m_snap [4];
    int         m_presc = 0;
    int         m_idx = 0;

    // Last segment pattern seen on each digit
    logic [6:0] seen_a [4];
    logic [6:0] seen_b [4];

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // DUT B has DP on digit 1, so only digits 3 and 2 may ever blank
    function automatic logic ref_blank_b(input int k);
`ifdef BCD_SCAN_BLANK_EN
        if (k == 3) return (m_snap[3] == 4'd0);
        if (k == 2) return (m_snap[3] == 4'd0) && (m_snap[2] == 4'd0);
`endif
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: push expectation for the coming edge, advance model, compare
    task automatic step();
        exp_t e;
        if (clear) begin
            e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, seg_b: 7'h7F, dp_b: 1'b1};
        end else begin
            e.an        = 4'hF;
            e.an[m_idx] = 1'b0;
            e.seg       = ref_seg(m_snap[m_idx]);
            e.dp        = (m_idx != 3);
            e.seg_b     = ref_blank_b(m_idx) ? 7'h7F : e.seg;
            e.dp_b      = (m_idx != 1);
        end
        sb.push_back(e);
        if (clear) begin
            for (int k = 0; k < 4; k++) m_snap[k] = 4'd0;
            m_presc = 0;
            m_idx   = 0;
        end else begin
            if (load) begin
                m_snap[3] = bcd3;
                m_snap[2] = bcd2;
                m_snap[1] = bcd1;
                m_snap[0] = bcd0;
            end
            if (m_presc == 3) begin
                m_presc = 0;
                m_idx   = (m_idx + 1) % 4;
            end else begin
                m_presc++;
            end
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("an_a",  {3'b0, an_a}, {3'b0, e.an});
        chk("seg_a", seg_a, e.seg);
        chk("dp_a",  {6'b0, dp_a}, {6'b0, e.dp});
        chk("an_b",  {3'b0, an_b}, {3'b0, e.an});
        chk("seg_b", seg_b, e.seg_b);
        chk("dp_b",  {6'b0, dp_b}, {6'b0, e.dp_b});
        for (int k = 0; k < 4; k++) begin
            if (an_a[k] === 1'b0) seen_a[k] = seg_a;
            if (an_b[k] === 1'b0) seen_b[k] = seg_b;
        end
    endtask

    task automatic frame();
        for (int i = 0; i < 16; i++) step();
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            m_snap[k] = 4'd0;
            seen_a[k] = 7'hxx;
            seen_b[k] = 7'hxx;
        end
        clear = 1'b1;
        load  = 1'b0;
        {bcd3, bcd2, bcd1, bcd0} = 16'h0000;

        // Reset values
        step();
        step();
        chk("rst_an",  {3'b0, an_a}, 7'b0001111);
        chk("rst_seg", seg_a, 7'b1111111);
        chk("rst_dp",  {6'b0, dp_a}, 7'd1);

        // Free-running scan of the zero snapshot
        clear = 1'b0;
        step();
        chk("first_an", {3'b0, an_a}, 7'b0001110);
        for (int i = 0; i < 15; i++) step();
        for (int k = 0; k < 4; k++) chk("zero_digit", seen_a[k], 7'b1000000);

        // Load 1,2,3,4
        {bcd3, bcd2, bcd1, bcd0} = 16'h1234;
        load = 1'b1;
        step();
        load = 1'b0;
        frame();
        chk("ld_d3", seen_a[3], 7'b1111001);
        chk("ld_d2", seen_a[2], 7'b0100100);
        chk("ld_d1", seen_a[1], 7'b0110000);
        chk("ld_d0", seen_a[0], 7'b0011001);

        // Load 9,0,0,5 on the tick leaving digit 3
        for (int i = 0; i < 16 && !(m_idx == 3 && m_presc == 3); i++) step();
        {bcd3, bcd2, bcd1, bcd0} = 16'h9005;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        chk("tick_an",  {3'b0, an_a}, 7'b0001110);
        chk("tick_seg", seg_a, 7'b0010010);

        // Non-BCD code on digit 0 shows a dash
        bcd0 = 4'hB;
        load = 1'b1;
        step();
        load = 1'b0;
        frame();
        chk("dash_d0", seen_a[0], 7'b0111111);
        chk("dash_d3", seen_a[3], 7'b0010000);

        // Clear in the middle of digit 2's dwell
        for (int i = 0; i < 16 && !(m_idx == 2 && m_presc == 1); i++) step();
        clear = 1'b1;
        step();
        chk("clr_an",  {3'b0, an_a}, 7'b0001111);
        chk("clr_seg", seg_a, 7'b1111111);
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("clr_dwell_an", {3'b0, an_a}, 7'b0001110);
        end
        step();
        chk("clr_next_an", {3'b0, an_a}, 7'b0001101);

        // Leading zeros: 0,0,0,7
        {bcd3, bcd2, bcd1, bcd0} = 16'h0007;
        load = 1'b1;
        step();
        load = 1'b0;
        frame();
`ifdef BCD_SCAN_BLANK_EN
        chk("blk_b_d3", seen_b[3], 7'b1111111);
        chk("blk_b_d2", seen_b[2], 7'b1111111);
`else
        chk("blk_b_d3", seen_b[3], 7'b1000000);
        chk("blk_b_d2", seen_b[2], 7'b1000000);
`endif
        chk("blk_b_d1", seen_b[1], 7'b1000000);
        chk("blk_b_d0", seen_b[0], 7'b1111000);
        chk("blk_a_d3", seen_a[3], 7'b1000000);
        chk("blk_a_d2", seen_a[2], 7'b1000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
